// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared types and constants for the MIDI UART transmit path.
//   parity_e          : parity mode chosen at elaboration
//   tx_state_e        : transmitter FSM state, also exported for debug
//   MIDI_CLKS_PER_BIT : 250 kHz / 31.25 kbaud
// -----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE,
        PAR_ODD,
        PAR_EVEN
    } parity_e;

    // Prefixed so the PARITY state cannot collide with a PARITY parameter.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_e;

    localparam int unsigned MIDI_CLKS_PER_BIT = 8;

endpackage

// File: rtl/uart_fifo.sv
// -----------------------------------------------------------------------------
// uart_fifo
// Synchronous FIFO feeding the UART serializer.
//   clk, rst        : clock, asynchronous active-low reset
//   push, wdata     : write request and data
//   pop, rdata      : read request; rdata shows the head entry (first-word
//                     fall-through)
//   full, empty     : occupancy flags, decoded from the level register
//   level           : current occupancy, 0..DEPTH
//   push_ok         : the push in this cycle is accepted
// A push into a full FIFO is still accepted when a pop happens in the same
// cycle. Pops on an empty FIFO are ignored. DEPTH must be a power of 2 so the
// pointers can wrap naturally.
// -----------------------------------------------------------------------------
module uart_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     push_ok
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q,  level_d;
    logic             do_push, do_pop;

    assign full    = (level_q == LVL_W'(DEPTH));
    assign empty   = (level_q == '0);
    assign level   = level_q;
    assign rdata   = mem_q[rd_ptr_q];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign push_ok = do_push;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (do_push && !do_pop)      level_d = level_q + LVL_W'(1);
        else if (do_pop && !do_push) level_d = level_q - LVL_W'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage needs no reset: an entry is only read after it was written.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/midi_uart_tx.sv
// -----------------------------------------------------------------------------
// midi_uart_tx
// FIFO-buffered UART transmitter for the MIDI OUT pin.
//   clk, rst     : sample clock, asynchronous active-low reset
//   tx_strobe    : push data into the FIFO on every rising edge it is high
//   data         : DATA_BITS-wide byte to enqueue
//   tx           : registered serial line, idles high
//   busy         : FIFO non-empty or a frame in progress
//   full, empty  : FIFO flags; level : FIFO occupancy
//   overflow     : one-cycle pulse after a rejected write
//   state_dbg    : current FSM state
// Frame: start, DATA_BITS data LSB first, optional parity, STOP_BITS stop bits,
// each bit CLKS_PER_BIT cycles. Legal ranges: DATA_BITS 5..9,
// CLKS_PER_BIT >= 2, FIFO_DEPTH a power of 2 >= 2, STOP_BITS 1 or 2.
// -----------------------------------------------------------------------------
module midi_uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned CLKS_PER_BIT = MIDI_CLKS_PER_BIT,
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter parity_e     PARITY       = PAR_NONE,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          tx_strobe,
    input  logic [DATA_BITS-1:0]          data,
    output logic                          tx,
    output logic                          busy,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          overflow,
    output tx_state_e                     state_dbg
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned BIT_W = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] CLK_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);
    localparam logic             PAR_INV   = (PARITY == PAR_ODD);

    tx_state_e            state_q,   state_d;
    logic [CNT_W-1:0]     clk_cnt_q, clk_cnt_d;
    logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q,   shift_d;
    logic                 par_q,     par_d;
    logic                 tx_q,      tx_d;
    logic                 overflow_q, overflow_d;

    logic                 pop, load, bit_end, push_ok, fifo_empty;
    logic [DATA_BITS-1:0] fifo_rdata;

    uart_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (tx_strobe),
        .wdata   (data),
        .pop     (pop),
        .rdata   (fifo_rdata),
        .full    (full),
        .empty   (fifo_empty),
        .level   (level),
        .push_ok (push_ok)
    );

    assign bit_end = (clk_cnt_q == CLK_LAST);

    // tx_d is always the line value for the state being entered, so the
    // registered tx changes on the same edge as the state.
    always_comb begin
        state_d   = state_q;
        clk_cnt_d = clk_cnt_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        par_d     = par_q;
        tx_d      = tx_q;
        load      = 1'b0;
        pop       = 1'b0;

        if (state_q != ST_IDLE) begin
            clk_cnt_d = bit_end ? '0 : clk_cnt_q + CNT_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                tx_d = 1'b1;
                if (!fifo_empty) load = 1'b1;
            end
            ST_START: begin
                if (bit_end) begin
                    state_d   = ST_DATA;
                    bit_cnt_d = '0;
                    tx_d      = shift_q[0];
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    if (bit_cnt_q == DATA_LAST) begin
                        bit_cnt_d = '0;
                        if (PARITY != PAR_NONE) begin
                            state_d = ST_PARITY;
                            tx_d    = par_q;
                        end else begin
                            state_d = ST_STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                        shift_d   = shift_q >> 1;
                        tx_d      = shift_q[1];
                    end
                end
            end
            ST_PARITY: begin
                if (bit_end) begin
                    state_d = ST_STOP;
                    tx_d    = 1'b1;
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    if (bit_cnt_q == STOP_LAST) begin
                        bit_cnt_d = '0;
                        // Chain straight into the next start bit when data waits.
                        if (!fifo_empty) begin
                            load = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                tx_d    = 1'b1;
            end
        endcase

        // Parity is taken from the whole word at load time because the shift
        // register is consumed as the bits go out.
        if (load) begin
            pop       = 1'b1;
            shift_d   = fifo_rdata;
            par_d     = (^fifo_rdata) ^ PAR_INV;
            state_d   = ST_START;
            clk_cnt_d = '0;
            bit_cnt_d = '0;
            tx_d      = 1'b0;
        end
    end

    assign overflow_d = tx_strobe && !push_ok;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            clk_cnt_q  <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            par_q      <= 1'b0;
            tx_q       <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            clk_cnt_q  <= clk_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            tx_q       <= tx_d;
            overflow_q <= overflow_d;
        end
    end

    assign tx        = tx_q;
    assign overflow  = overflow_q;
    assign empty     = fifo_empty;
    assign busy      = !fifo_empty || (state_q != ST_IDLE);
    assign state_dbg = state_q;

endmodule

// File: tb/tb_midi_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_midi_uart_tx
// Bench for midi_uart_tx. dut1 uses the default 8N1 MIDI framing, dut2 uses
// 7 data bits, even parity and 2 stop bits. A line monitor decodes frames on
// the selected tx line and compares them with the expected-frame queue.
// Frames are held LSB first: bit 0 is the start bit.
// Handshake: a byte is offered by holding tx_strobe high across one rising
// edge; there is no ready, acceptance is decided by the FIFO state.
// -----------------------------------------------------------------------------
module tb_midi_uart_tx;
    import uart_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic rst;

    // ---------------- DUT 1: 8N1 ----------------
    logic       strobe1;
    logic [7:0] data1;
    logic       tx1, busy1, full1, empty1, ovf1;
    logic [2:0] level1;
    tx_state_e  st1;

    midi_uart_tx dut1 (
        .clk       (clk),
        .rst       (rst),
        .tx_strobe (strobe1),
        .data      (data1),
        .tx        (tx1),
        .busy      (busy1),
        .full      (full1),
        .empty     (empty1),
        .level     (level1),
        .overflow  (ovf1),
        .state_dbg (st1)
    );

    // ---------------- DUT 2: 7E2 ----------------
    logic       strobe2;
    logic [6:0] data2;
    logic       tx2, busy2, full2, empty2, ovf2;
    logic [2:0] level2;
    tx_state_e  st2;

    midi_uart_tx #(
        .DATA_BITS (7),
        .PARITY    (PAR_EVEN),
        .STOP_BITS (2)
    ) dut2 (
        .clk       (clk),
        .rst       (rst),
        .tx_strobe (strobe2),
        .data      (data2),
        .tx        (tx2),
        .busy      (busy2),
        .full      (full2),
        .empty     (empty2),
        .level     (level2),
        .overflow  (ovf2),
        .state_dbg (st2)
    );

    // ---------------- scoreboard ----------------
    int          n_vec = 0;
    int          n_err = 0;
    logic [15:0] exp_q[$];
    int          fall_q[$];
    logic        mon_sel   = 1'b0;
    int          mon_nbits = 10;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step_to(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    function automatic logic [15:0] frame8(input logic [7:0] d);
        return {6'b0, 1'b1, d, 1'b0};
    endfunction

    // Line monitor: a low level while idle starts a frame; every bit is
    // sampled mid-way through its 8-cycle slot.
    initial begin : monitor
        logic        line;
        bit          act;
        int          off;
        logic [15:0] frm;
        logic [15:0] e;
        act = 1'b0;
        off = 0;
        frm = '0;
        forever begin
            @(negedge clk);
            line = mon_sel ? tx2 : tx1;
            if (!rst) begin
                act = 1'b0;
            end else if (!act) begin
                if (line == 1'b0) begin
                    act = 1'b1;
                    off = 0;
                    frm = '0;
                    fall_q.push_back(cyc);
                end
            end else begin
                off++;
            end
            if (act && (off % 8 == 4)) begin
                frm[off / 8] = line;
                if (off / 8 == mon_nbits - 1) begin
                    act = 1'b0;
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_frame: got 0x%0h, expected no frame (cycle %0d)", frm, cyc);
                    end else begin
                        e = exp_q.pop_front();
                        check("frame", frm, e);
                    end
                end
            end
        end
    end

    // ---------------- vector table ----------------
    typedef struct {
        logic [7:0]  data;
        logic [15:0] frame;
    } vec_t;

    vec_t       vecs [5];
    logic [7:0] seq_data [6];

    initial begin : main
        int s;
        rst     = 1'b0;
        strobe1 = 1'b0;
        data1   = '0;
        strobe2 = 1'b0;
        data2   = '0;

        vecs[0] = '{8'h80, 16'h0300};
        vecs[1] = '{8'h55, 16'h02AA};
        vecs[2] = '{8'h00, 16'h0200};
        vecs[3] = '{8'hFF, 16'h03FE};
        vecs[4] = '{8'hA5, 16'h034A};

        seq_data[0] = 8'hA1;
        seq_data[1] = 8'hB2;
        seq_data[2] = 8'hC3;
        seq_data[3] = 8'hD4;
        seq_data[4] = 8'hE5;
        seq_data[5] = 8'hF6;

        // ---- reset values ----
        repeat (3) @(negedge clk);
        check("rst_tx",       tx1,    1);
        check("rst_busy",     busy1,  0);
        check("rst_full",     full1,  0);
        check("rst_empty",    empty1, 1);
        check("rst_level",    level1, 0);
        check("rst_overflow", ovf1,   0);
        check("rst_state",    st1,    ST_IDLE);
        check("rst_tx2",      tx2,    1);
        rst = 1'b1;
        repeat (3) @(negedge clk);

        // ---- single bytes from the table ----
        foreach (vecs[i]) begin
            fall_q.delete();
            s = cyc;
            strobe1 = 1'b1;
            data1   = vecs[i].data;
            exp_q.push_back(vecs[i].frame);
            @(negedge clk);
            strobe1 = 1'b0;
            check("tbl_level",   level1, 1);
            check("tbl_empty",   empty1, 0);
            check("tbl_busy",    busy1,  1);
            check("tbl_tx_idle", tx1,    1);
            step_to(s + 81);
            check("tbl_busy_held", busy1, 1);
            step_to(s + 82);
            check("tbl_busy_fall", busy1, 0);
            check("tbl_pending",   exp_q.size(), 0);
            check("tbl_falls",     fall_q.size(), 1);
            if (fall_q.size() > 0) check("tbl_fall_cycle", fall_q[0], s + 2);
            repeat (2) @(negedge clk);
        end

        // ---- back-to-back: three strobes on consecutive cycles ----
        fall_q.delete();
        s = cyc;
        strobe1 = 1'b1;
        data1   = 8'h90;
        exp_q.push_back(frame8(8'h90));
        @(negedge clk);
        check("b2b_level0", level1, 1);
        data1 = 8'h3C;
        exp_q.push_back(frame8(8'h3C));
        @(negedge clk);
        check("b2b_level1", level1, 1);
        data1 = 8'h64;
        exp_q.push_back(frame8(8'h64));
        @(negedge clk);
        strobe1 = 1'b0;
        check("b2b_level2", level1, 2);
        step_to(s + 241);
        check("b2b_busy_held", busy1, 1);
        step_to(s + 242);
        check("b2b_busy_fall", busy1, 0);
        check("b2b_pending",   exp_q.size(), 0);
        check("b2b_falls",     fall_q.size(), 3);
        if (fall_q.size() == 3) begin
            check("b2b_fall0", fall_q[0], s + 2);
            check("b2b_fall1", fall_q[1], s + 82);
            check("b2b_fall2", fall_q[2], s + 162);
        end
        repeat (2) @(negedge clk);

        // ---- overflow: six strobes into a depth-4 FIFO ----
        fall_q.delete();
        s = cyc;
        for (int k = 0; k < 6; k++) begin
            strobe1 = 1'b1;
            data1   = seq_data[k];
            if (k < 5) exp_q.push_back(frame8(seq_data[k]));
            @(negedge clk);
            if (k == 4) begin
                check("ovf_level_full", level1, 4);
                check("ovf_full",       full1,  1);
                check("ovf_not_yet",    ovf1,   0);
            end
            if (k == 5) begin
                check("ovf_pulse",      ovf1,   1);
                check("ovf_level_kept", level1, 4);
            end
        end
        strobe1 = 1'b0;
        @(negedge clk);
        check("ovf_pulse_end", ovf1, 0);
        step_to(s + 401);
        check("ovf_busy_held", busy1, 1);
        step_to(s + 402);
        check("ovf_busy_fall", busy1, 0);
        check("ovf_pending",   exp_q.size(), 0);
        check("ovf_falls",     fall_q.size(), 5);
        repeat (2) @(negedge clk);

        // ---- full FIFO, write on the end-of-stop pop cycle ----
        fall_q.delete();
        s = cyc;
        for (int k = 0; k < 5; k++) begin
            strobe1 = 1'b1;
            data1   = seq_data[k];
            exp_q.push_back(frame8(seq_data[k]));
            @(negedge clk);
        end
        strobe1 = 1'b0;
        check("fp_full",  full1,  1);
        check("fp_level", level1, 4);
        step_to(s + 81);
        strobe1 = 1'b1;
        data1   = 8'h3A;
        exp_q.push_back(frame8(8'h3A));
        @(negedge clk);
        strobe1 = 1'b0;
        check("fp_no_ovf",      ovf1,   0);
        check("fp_level_kept",  level1, 4);
        check("fp_still_full",  full1,  1);
        @(negedge clk);
        check("fp_no_ovf_late", ovf1,   0);
        step_to(s + 481);
        check("fp_busy_held", busy1, 1);
        step_to(s + 482);
        check("fp_busy_fall", busy1, 0);
        check("fp_pending",   exp_q.size(), 0);
        check("fp_falls",     fall_q.size(), 6);
        repeat (2) @(negedge clk);

        // ---- reset during data bit 3 with two entries queued ----
        s = cyc;
        for (int k = 0; k < 3; k++) begin
            strobe1 = 1'b1;
            data1   = (k == 0) ? 8'hF0 : seq_data[k];
            @(negedge clk);
        end
        strobe1 = 1'b0;
        check("rmf_level", level1, 2);
        step_to(s + 37);
        check("rmf_tx_low", tx1, 0);
        #2 rst = 1'b0;
        #1;
        check("rmf_tx",    tx1,    1);
        check("rmf_empty", empty1, 1);
        check("rmf_busy",  busy1,  0);
        check("rmf_level0", level1, 0);
        check("rmf_state", st1,    ST_IDLE);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rmf_quiet_tx",   tx1,   1);
        check("rmf_quiet_busy", busy1, 0);
        fall_q.delete();
        s = cyc;
        strobe1 = 1'b1;
        data1   = 8'h55;
        exp_q.push_back(16'h02AA);
        @(negedge clk);
        strobe1 = 1'b0;
        step_to(s + 81);
        check("rmf_busy_held", busy1, 1);
        step_to(s + 82);
        check("rmf_busy_fall", busy1, 0);
        check("rmf_pending",   exp_q.size(), 0);
        check("rmf_falls",     fall_q.size(), 1);
        if (fall_q.size() > 0) check("rmf_fall_cycle", fall_q[0], s + 2);
        repeat (2) @(negedge clk);

        // ---- 7E2 frame on dut2 ----
        mon_sel   = 1'b1;
        mon_nbits = 11;
        fall_q.delete();
        s = cyc;
        strobe2 = 1'b1;
        data2   = 7'h45;
        exp_q.push_back(16'h078A);
        @(negedge clk);
        strobe2 = 1'b0;
        check("par_level", level2, 1);
        step_to(s + 89);
        check("par_busy_held", busy2, 1);
        step_to(s + 90);
        check("par_busy_fall", busy2, 0);
        check("par_pending",   exp_q.size(), 0);
        check("par_falls",     fall_q.size(), 1);
        if (fall_q.size() > 0) check("par_fall_cycle", fall_q[0], s + 2);
        check("par_other_idle", tx1, 1);
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
